sata_cmd_issuer: RTL

- Initiator-side driver for the SATA host command/data user interface.
- Accepts one read or write request from an upstream client and issues it to the host as a single-cycle new_cmd.
- Streams the sector data: write words into the host input FIFO, or read words out of the host output FIFO.
- Reports completion or abort; sits between the client logic and the SATA host core.

---
 rtl/sata_cmd_issuer_if.sv | 53 +++++
 rtl/sata_cmd_issuer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sata_cmd_issuer_if.sv
// rtl/sata_cmd_issuer_if.sv - client request/data and SATA host user-interface signal bundle
interface sata_cmd_issuer_if;
  // client request
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_count;
  logic [31:0] req_addr;
  // client write stream
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  // client read stream
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  // client status
  logic        busy;
  logic        done;
  logic        err;
  // host command side
  logic        ready_for_cmd;
  logic        new_cmd;
  logic [1:0]  cmd_type;
  logic [31:0] sector_count;
  logic [31:0] sector_addr;
  // host data FIFOs
  logic [31:0] sata_din;
  logic        sata_din_we;
  logic        sata_core_full;
  logic [31:0] sata_dout;
  logic        sata_dout_re;
  logic        sata_core_empty;
  // host status
  logic        sata_timer;
  logic        linkup;

  modport master (
    input  req_valid, req_type, req_count, req_addr,
    input  wr_data, wr_valid, rd_ready,
    input  ready_for_cmd, sata_core_full, sata_dout, sata_core_empty, sata_timer, linkup,
    output req_ready, wr_ready, rd_data, rd_valid, busy, done, err,
    output new_cmd, cmd_type, sector_count, sector_addr, sata_din, sata_din_we, sata_dout_re
  );

  modport slave (
    output req_valid, req_type, req_count, req_addr,
    output wr_data, wr_valid, rd_ready,
    output ready_for_cmd, sata_core_full, sata_dout, sata_core_empty, sata_timer, linkup,
    input  req_ready, wr_ready, rd_data, rd_valid, busy, done, err,
    input  new_cmd, cmd_type, sector_count, sector_addr, sata_din, sata_din_we, sata_dout_re
  );
endinterface

// File: rtl/sata_cmd_issuer.sv
// rtl/sata_cmd_issuer.sv - issues one SATA read/write command and streams its sector data
module sata_cmd_issuer #(
  parameter int WORDS_PER_SECTOR = 128,
  parameter int SECT_SHIFT       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  sata_cmd_issuer_if.master  bus
);

  // Word counter is wide enough that a full 32-bit sector count never overflows.
  localparam int RemW = 32 + $clog2(WORDS_PER_SECTOR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t            state_q,        state_d;
  logic [RemW-1:0]   remaining_q,    remaining_d;
  logic [1:0]        cmd_type_q,     cmd_type_d;
  logic [31:0]       sector_count_q, sector_count_d;
  logic [31:0]       sector_addr_q,  sector_addr_d;
  logic              req_ready_q,    req_ready_d;
  logic              busy_q,         busy_d;
  logic              done_q,         done_d;
  logic              err_q,          err_d;
  logic              new_cmd_q,      new_cmd_d;

  logic abort;
  logic req_legal;
  logic wr_xfer;
  logic rd_vld;
  logic rd_xfer;

  assign abort     = bus.sata_timer | ~bus.linkup;
  assign req_legal = (bus.req_type == 2'b01) || (bus.req_type == 2'b10);

  // Data handshakes are combinational pass-throughs, forced to 0 outside their own state.
  assign wr_xfer = (state_q == S_WRITE) & bus.wr_valid & ~bus.sata_core_full;
  assign rd_vld  = (state_q == S_READ) & ~bus.sata_core_empty;
  assign rd_xfer = rd_vld & bus.rd_ready;

  assign bus.sata_din_we  = wr_xfer;
  assign bus.wr_ready     = wr_xfer;
  assign bus.sata_din     = (state_q == S_WRITE) ? bus.wr_data : 32'd0;
  assign bus.rd_valid     = rd_vld;
  assign bus.sata_dout_re = rd_xfer;
  assign bus.rd_data      = (state_q == S_READ) ? bus.sata_dout : 32'd0;

  assign bus.req_ready    = req_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.new_cmd      = new_cmd_q;
  assign bus.cmd_type     = cmd_type_q;
  assign bus.sector_count = sector_count_q;
  assign bus.sector_addr  = sector_addr_q;

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    cmd_type_d     = cmd_type_q;
    sector_count_d = sector_count_q;
    sector_addr_d  = sector_addr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    new_cmd_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          cmd_type_d     = bus.req_type;
          sector_count_d = bus.req_count;
          sector_addr_d  = bus.req_addr;
          remaining_d    = {{(RemW-32){1'b0}}, bus.req_count} << SECT_SHIFT;
          if ((bus.req_count == 32'd0) || !req_legal) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            busy_d  = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // Only the host timer aborts here; a dropped link just keeps us waiting.
        if (bus.sata_timer) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (bus.ready_for_cmd && bus.linkup) begin
          new_cmd_d = 1'b1;
          state_d   = (cmd_type_q == 2'b10) ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (wr_xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == RemW'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (rd_xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == RemW'(1)) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Ready is registered so it reappears the cycle after DONE and after reset release.
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      cmd_type_q     <= 2'b00;
      sector_count_q <= 32'd0;
      sector_addr_q  <= 32'd0;
      req_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      new_cmd_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      cmd_type_q     <= cmd_type_d;
      sector_count_q <= sector_count_d;
      sector_addr_q  <= sector_addr_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      new_cmd_q      <= new_cmd_d;
    end
  end

endmodule
